// File: rtl/mtree_pkg.sv
// mtree_pkg
//   Definitions shared by the max-tree reduction controller and its
//   comparator stage: the controller state encoding and the helper that
//   gives the number of fold passes needed to collapse the lane register.
package mtree_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,  // accepting words into lanes 1..L-1
    REDUCE = 2'd1,  // folding lanes through the shared comparator stage
    OUT    = 2'd2   // presenting the frame result
  } mtree_ctrl_state_t;

  // Folds needed to bring 2*num_comps lanes down to lane 0.
  function automatic int mtree_passes(input int num_comps);
    return $clog2(2 * num_comps);
  endfunction

endpackage : mtree_pkg

// File: rtl/mtree_level.sv
// mtree_level
//   One level of an unsigned max tree: NUM_COMPS comparators, each one
//   taking an adjacent operand pair (2i, 2i+1) and passing the larger.
//   Purely combinational.
// Ports
//   operands  in   2*NUM_COMPS words of IN_WIDTH bits, unsigned
//   maxima    out  NUM_COMPS words, maxima[i] = max(operands[2i], operands[2i+1])
module mtree_level #(
  parameter int IN_WIDTH  = 32,
  parameter int NUM_COMPS = 4
) (
  input  logic [IN_WIDTH-1:0] operands [2*NUM_COMPS],
  output logic [IN_WIDTH-1:0] maxima   [NUM_COMPS]
);

  always_comb begin
    for (int i = 0; i < NUM_COMPS; i++) begin
      maxima[i] = (operands[2*i] > operands[2*i+1]) ? operands[2*i] : operands[2*i+1];
    end
  end

endmodule : mtree_level

// File: rtl/mtree_reduce_ctrl.sv
// mtree_reduce_ctrl
//   Computes the unsigned maximum and word count of a stream frame using a
//   single shared mtree_level. Words are buffered into lanes 1..L-1 (lane 0
//   carries the running maximum); a full chunk or the frame's last word
//   triggers log2(L) fold passes, after which lane 0 holds the new running
//   maximum. One result is emitted per frame.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input word valid
//   in_ready   out  controller accepts a word this cycle
//   in_data    in   IN_WIDTH input word, unsigned
//   in_last    in   word is the final word of its frame
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_max    out  IN_WIDTH unsigned maximum of the frame
//   out_count  out  CNT_WIDTH words in the frame, saturating
module mtree_reduce_ctrl
  import mtree_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int NUM_COMPS = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IN_WIDTH-1:0]  out_max,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam int LANES  = 2 * NUM_COMPS;
  localparam int PASSES = mtree_passes(NUM_COMPS);
  localparam int PTR_W  = $clog2(LANES);
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  // The lane/pass arithmetic below only works for a power-of-two tree.
  if (NUM_COMPS < 1 || (NUM_COMPS & (NUM_COMPS - 1)) != 0) begin : g_bad_num_comps
    $error("mtree_reduce_ctrl: NUM_COMPS must be a power of two >= 1");
  end

  mtree_ctrl_state_t state, next_state;

  logic [IN_WIDTH-1:0]  lanes  [LANES];
  logic [IN_WIDTH-1:0]  folded [NUM_COMPS];
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [PASS_W-1:0]    pass_cnt;
  logic                 last_seen;   // current chunk closed the frame

  logic accept;
  logic chunk_full;
  logic last_pass;

  assign accept     = in_valid && (state == FILL);
  assign chunk_full = (wr_ptr == PTR_W'(LANES - 1));
  assign last_pass  = (pass_cnt == PASS_W'(PASSES - 1));

  mtree_level #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_COMPS (NUM_COMPS)
  ) u_level (
    .operands (lanes),
    .maxima   (folded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= next_state;
  end

  // Outputs are decoded from the state register and registered lanes/count
  // only, so no input handshake signal reaches an output combinationally.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_max    = '0;
    out_count  = '0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && (in_last || chunk_full)) next_state = REDUCE;
      end
      REDUCE: begin
        if (last_pass) next_state = last_seen ? OUT : FILL;
      end
      OUT: begin
        out_valid = 1'b1;
        out_max   = lanes[0];
        out_count = count;
        if (out_ready) next_state = FILL;
      end
      default: next_state = FILL;
    endcase
  end

  // NOTE: state-holding logic uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the lanes are reset, not left undefined, because zero is the
      // identity for an unsigned max and unwritten lanes must read as zero.
      for (int i = 0; i < LANES; i++) lanes[i] <= '0;
      wr_ptr    <= PTR_W'(1);
      count     <= '0;
      pass_cnt  <= '0;
      last_seen <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            lanes[wr_ptr] <= in_data;
            wr_ptr        <= wr_ptr + PTR_W'(1);
            if (count != '1) count <= count + CNT_WIDTH'(1);
            last_seen     <= in_last;
            pass_cnt      <= '0;
          end
        end
        REDUCE: begin
          for (int i = 0; i < NUM_COMPS; i++) lanes[i] <= folded[i];
          for (int i = NUM_COMPS; i < LANES; i++) lanes[i] <= '0;
          pass_cnt <= pass_cnt + PASS_W'(1);
          if (last_pass) begin
            // Lane 0 keeps the running max; the data lanes start empty.
            for (int i = 1; i < LANES; i++) lanes[i] <= '0;
            pass_cnt <= '0;
            wr_ptr   <= PTR_W'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            for (int i = 0; i < LANES; i++) lanes[i] <= '0;
            wr_ptr    <= PTR_W'(1);
            count     <= '0;
            last_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : mtree_reduce_ctrl

// File: tb/tb_mtree_reduce_ctrl.sv
// tb_mtree_reduce_ctrl
//   Self-checking bench for mtree_reduce_ctrl (NUM_COMPS=4, IN_WIDTH=32).
//   A table of frames with hand-computed results is replayed in a loop;
//   reset during REDUCE and during OUT are covered by hand-written sequences.
module tb_mtree_reduce_ctrl;

  localparam int IN_WIDTH  = 32;
  localparam int NUM_COMPS = 4;
  localparam int CNT_WIDTH = 16;
  localparam int P         = 3;
  localparam int NVEC      = 7;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [IN_WIDTH-1:0]  out_max;
  logic [CNT_WIDTH-1:0] out_count;

  mtree_reduce_ctrl #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_COMPS (NUM_COMPS),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                      n;
    logic [15:0][31:0]       w;
    logic [31:0]             exp_max;
    int                      exp_cnt;
    int                      exp_stalls;
    int                      hold;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [31:0] cur_w [16];
  int          tests  = 0;
  int          failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives cur_w[0..n-1] starting at a negedge; returns the number of
  // cycles in_ready was low while a word was pending. Ends at the negedge
  // after the edge that accepted the last word.
  task automatic send_words(input int n, output int stalls);
    int guard;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = cur_w[k];
      in_last  = (k == n - 1);
      guard    = 0;
      while (!in_ready && guard < 50) begin
        stalls++;
        guard++;
        @(negedge clk);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Waits for the result, checks latency/value/count, holds out_ready low
  // for 'hold' cycles, then completes the handshake.
  task automatic collect(input string name, input logic [31:0] exp_max,
                         input int exp_cnt, input int hold);
    int lat;
    logic ok;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, P);
    check({name, "_max"}, out_max, exp_max);
    check({name, "_count"}, out_count, exp_cnt);
    if (hold > 0) begin
      ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!out_valid || out_max !== exp_max || out_count !== exp_cnt[CNT_WIDTH-1:0] || in_ready)
          ok = 1'b0;
      end
      check({name, "_hold_stable"}, ok, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_ready_after_hs"}, {in_ready, out_valid}, 2'b10);
  endtask

  task automatic set_vec(input int idx, input int n, input logic [31:0] mx,
                         input int cnt, input int stalls, input int hold);
    vecs[idx].n          = n;
    vecs[idx].exp_max    = mx;
    vecs[idx].exp_cnt    = cnt;
    vecs[idx].exp_stalls = stalls;
    vecs[idx].hold       = hold;
  endtask

  initial begin
    int stalls;

    // Frame table: words plus hand-computed max, count, stall cycles.
    for (int v = 0; v < NVEC; v++) vecs[v].w = '0;
    set_vec(0, 3, 32'd9, 3, 0, 0);
    vecs[0].w[0] = 32'd5; vecs[0].w[1] = 32'd9; vecs[0].w[2] = 32'd2;
    set_vec(1, 10, 32'h77, 10, 3, 0);
    for (int k = 0; k < 10; k++) vecs[1].w[k] = 32'(k + 1);
    vecs[1].w[8] = 32'h77;
    set_vec(2, 1, 32'd0, 1, 0, 0);
    set_vec(3, 2, 32'hFFFF_FFFF, 2, 0, 0);
    vecs[3].w[0] = 32'hFFFF_FFFF; vecs[3].w[1] = 32'd3;
    set_vec(4, 7, 32'd42, 7, 0, 0);
    vecs[4].w[0] = 32'd1;  vecs[4].w[1] = 32'd17; vecs[4].w[2] = 32'd3;
    vecs[4].w[3] = 32'd42; vecs[4].w[4] = 32'd5;  vecs[4].w[5] = 32'd41;
    vecs[4].w[6] = 32'd7;
    set_vec(5, 2, 32'd8, 2, 0, 5);
    vecs[5].w[0] = 32'd8; vecs[5].w[1] = 32'd4;
    // 15 words, max in the first chunk: two chunk penalties, running max carried.
    set_vec(6, 15, 32'd200, 15, 6, 0);
    for (int k = 0; k < 15; k++) vecs[6].w[k] = 32'(k + 10);
    vecs[6].w[0] = 32'd200;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_outputs", {out_valid, out_max, out_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);

    for (int v = 0; v < NVEC; v++) begin
      for (int k = 0; k < 16; k++) cur_w[k] = vecs[v].w[k];
      send_words(vecs[v].n, stalls);
      check($sformatf("vec%0d_stalls", v), stalls, vecs[v].exp_stalls);
      collect($sformatf("vec%0d", v), vecs[v].exp_max, vecs[v].exp_cnt, vecs[v].hold);
    end

    // Reset in the middle of REDUCE discards the partial frame.
    cur_w[0] = 32'd100; cur_w[1] = 32'd200;
    send_words(2, stalls);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_reduce_outputs", {out_valid, out_max, out_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_reduce_in_ready", in_ready, 1'b1);
    cur_w[0] = 32'd3;
    send_words(1, stalls);
    collect("after_rst_reduce", 32'd3, 1, 0);

    // Reset while a result is being presented clears it at once.
    cur_w[0] = 32'd50;
    send_words(1, stalls);
    repeat (P) @(negedge clk);
    check("rst_out_valid_before", {out_valid, out_max}, {1'b1, 32'd50});
    rst_n = 1'b0;
    #1;
    check("rst_out_outputs", {out_valid, out_max, out_count}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cur_w[0] = 32'd6; cur_w[1] = 32'd11;
    send_words(2, stalls);
    collect("after_rst_out", 32'd11, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_mtree_reduce_ctrl

// File: doc/mtree_reduce_ctrl.md
# mtree_reduce_ctrl

Sequencing controller that computes the unsigned maximum of an arbitrary-length input stream ("frame") using one shared `mtree_level` comparator stage. It buffers input words into a lane register, repeatedly folds the lanes through the comparator stage until lane 0 holds the running maximum, and emits one result per frame. It sits between a valid/ready word source and a valid/ready result consumer in the comparison datapath.

## Interface
- `IN_WIDTH`, 32: bits per data word.
- `NUM_COMPS`, 4: comparators in the shared `mtree_level`. Must be a power of two, ≥1. Lane count L = 2·NUM_COMPS.
- `CNT_WIDTH`, 16: width of the frame element counter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  controller accepts a word this cycle.
- `in_data`  in  IN_WIDTH  input word, unsigned.
- `in_last`  in  1  word is the final word of its frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_max`  out  IN_WIDTH  unsigned maximum of the frame.
- `out_count`  out  CNT_WIDTH  words in the frame, saturating at all-ones.

## Operation
- Lane register `lanes[0..L-1]`. Lane 0 holds the running max; lanes 1..L-1 take data.
- States: FILL, REDUCE, OUT.
- FILL: `in_ready`=1. Each accepted word (`in_valid && in_ready`) is written to lane `wr_ptr` (starting at 1), then `wr_ptr` increments and the count increments (saturating). After lane L-1 is written, or when `in_last` is accepted, the next state is REDUCE. Lanes not written in this chunk hold 0, the identity for an unsigned max.
- REDUCE: `in_ready`=0. The state lasts P = log2(L) cycles. Each cycle, `lanes[i] <= mtree_level.outputs[i]` for i < NUM_COMPS, and `lanes[i] <= 0` for i ≥ NUM_COMPS. The comparator inputs are `lanes` in order, so lanes 2i and 2i+1 feed comparator i.
- After P passes, lane 0 holds the max of the previous running max and the chunk.
  - If the chunk ended on `in_last`, go to OUT.
  - Otherwise go to FILL with `wr_ptr`=1, lanes 1..L-1 cleared and lane 0 kept.
- OUT: `out_valid`=1, `out_max`=lane 0, `out_count`=count. These outputs stay stable until `out_ready`. On the handshake, go to FILL with all lanes, `wr_ptr` and count cleared.
- A frame always contains at least one word; an empty frame cannot occur.
- `in_last` on the word that fills lane L-1 is a single event: go to REDUCE, then OUT.
- Count saturation does not affect `out_max`.

## Timing
- Reset (asynchronous on `rst_n` low, from any state, including mid-REDUCE or OUT):
  - state=FILL, lanes=0, `wr_ptr`=1, count=0;
  - `in_ready`=1 once `rst_n` is high;
  - `out_valid`=0, `out_max`=0, `out_count`=0.
  - A partial frame is discarded.
- Throughput in FILL: one word per cycle.
- Chunk penalty: P cycles with `in_ready`=0 after every L-1 accepted words.
- Latency: `out_valid` rises P cycles after the clock edge that accepts the `in_last` word. For NUM_COMPS=4, P=3.
- The OUT handshake edge returns to FILL. `in_ready` is high in the following cycle, and there is no dead cycle.
- All outputs are registered, or decoded only from the state register. There is no combinational path from `in_valid`/`out_ready` to any output.

## Structure
- Shared package `mtree_pkg`:
  - state enum `mtree_ctrl_state_t` {FILL, REDUCE, OUT};
  - function `mtree_passes(num_comps)` returning log2(2·num_comps).
- One sub-module: the existing `mtree_level` (IN_WIDTH, NUM_COMPS). It is instantiated once, with inputs driven directly from `lanes`.
- Elaboration check: NUM_COMPS is a power of two.

## Test plan
All cases use NUM_COMPS=4, IN_WIDTH=32.
- Frame {5, 9, 2}, last on 2 -> `out_max`=9, `out_count`=3, `out_valid` 3 cycles after the last-beat edge.
- Frame of 10 words, values 1..10 with 0x00000077 at index 8 -> `in_ready` drops for 3 cycles after word 7; `out_max`=0x77, `out_count`=10.
- Single word 0x0 with last -> `out_max`=0, `out_count`=1. Then frame {0xFFFFFFFF, 3} -> `out_max`=0xFFFFFFFF, `out_count`=2, with no carry-over from the prior frame.
- Frame of exactly 7 words, last on the 7th, max 42 -> exactly one REDUCE phase, then OUT; `out_count`=7.
- Frame {8, 4} with `out_ready` held low 5 cycles -> `out_valid`/`out_max`=8 stable throughout and `in_ready`=0. Release -> one handshake, and `in_ready`=1 the next cycle.
- Frame {100, 200} interrupted by `rst_n` low during REDUCE -> all outputs 0 at once. Then frame {3} -> `out_max`=3, `out_count`=1.
